// File: rtl/layer_sequencer.sv
// ============================================================================
// Module   : layer_sequencer
// Purpose  : Row-at-a-time control for one fully-connected layer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_sequencer #(
    parameter int M  = 5,
    parameter int N  = 4,
    parameter int RW = (M > 1) ? $clog2(M) : 1,
    parameter int CW = (N > 1) ? $clog2(N) : 1,
    parameter int AW = (M * N > 1) ? $clog2(M * N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] w_addr,
    output logic [CW-1:0] x_idx,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          bias_en,
    output logic [RW-1:0] b_idx,
    output logic          relu_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_BIAS  = 3'd4;
    localparam logic [2:0] S_ACT   = 3'd5;
    localparam logic [2:0] S_WRITE = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [RW-1:0] C_LAST_ROW = RW'(M - 1);
    localparam logic [CW-1:0] C_LAST_COL = CW'(N - 1);

    logic [2:0]    r_state, w_state_n;
    logic [RW-1:0] r_row, w_row_n;
    logic [CW-1:0] r_col, w_col_n;

    logic          w_busy_n, w_done_n, w_rd_en_n, w_mac_clr_n, w_mac_en_n;
    logic          w_bias_en_n, w_relu_en_n, w_out_valid_n;
    logic [AW-1:0] w_addr_n;
    logic [CW-1:0] w_x_idx_n;
    logic [RW-1:0] w_b_idx_n, w_out_idx_n;

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            w_addr    <= '0;
            x_idx     <= '0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            bias_en   <= 1'b0;
            b_idx     <= '0;
            relu_en   <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            r_state   <= w_state_n;
            r_row     <= w_row_n;
            r_col     <= w_col_n;
            busy      <= w_busy_n;
            done      <= w_done_n;
            rd_en     <= w_rd_en_n;
            w_addr    <= w_addr_n;
            x_idx     <= w_x_idx_n;
            mac_clr   <= w_mac_clr_n;
            mac_en    <= w_mac_en_n;
            bias_en   <= w_bias_en_n;
            b_idx     <= w_b_idx_n;
            relu_en   <= w_relu_en_n;
            out_valid <= w_out_valid_n;
            out_idx   <= w_out_idx_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_row_n   = r_row;
        w_col_n   = r_col;
        if (abort && (r_state != S_IDLE)) begin
            w_state_n = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_n = S_CLR;
                        w_row_n   = '0;
                        w_col_n   = '0;
                    end
                end
                S_CLR: begin
                    w_state_n = S_ISSUE;
                    w_col_n   = '0;
                end
                S_ISSUE: begin
                    if (r_col == C_LAST_COL) w_state_n = S_DRAIN;
                    else                     w_col_n   = r_col + 1'b1;
                end
                S_DRAIN: w_state_n = S_BIAS;
                S_BIAS:  w_state_n = S_ACT;
                S_ACT:   w_state_n = S_WRITE;
                S_WRITE: begin
                    if (out_ready) begin
                        if (r_row == C_LAST_ROW) begin
                            w_state_n = S_DONE;
                        end else begin
                            w_state_n = S_CLR;
                            w_row_n   = r_row + 1'b1;
                            w_col_n   = '0;
                        end
                    end
                end
                S_DONE:  w_state_n = S_IDLE;
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // mac_en tracks rd_en one cycle late: every ISSUE beat after the first,
    // plus DRAIN for the final product.
    always_comb begin
        w_busy_n      = (w_state_n != S_IDLE);
        w_done_n      = (w_state_n == S_DONE);
        w_mac_clr_n   = (w_state_n == S_CLR);
        w_rd_en_n     = (w_state_n == S_ISSUE);
        w_mac_en_n    = ((w_state_n == S_ISSUE) && (w_col_n != '0)) || (w_state_n == S_DRAIN);
        w_bias_en_n   = (w_state_n == S_BIAS);
        w_relu_en_n   = (w_state_n == S_ACT);
        w_out_valid_n = (w_state_n == S_WRITE);
        w_addr_n      = '0;
        w_x_idx_n     = '0;
        w_b_idx_n     = '0;
        w_out_idx_n   = '0;
        if (w_state_n == S_ISSUE) begin
            w_addr_n  = AW'(w_row_n) * AW'(N) + AW'(w_col_n);
            w_x_idx_n = w_col_n;
        end
        if (w_state_n == S_BIAS)  w_b_idx_n   = w_row_n;
        if (w_state_n == S_WRITE) w_out_idx_n = w_row_n;
    end

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// ============================================================================
// Module   : tb_layer_sequencer
// Purpose  : Directed self-checking bench for layer_sequencer (5x4 and 1x1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start0, abort0, out_ready0;
    logic       busy0, done0, rd_en0, mac_clr0, mac_en0, bias_en0, relu_en0, out_valid0;
    logic [4:0] w_addr0;
    logic [1:0] x_idx0;
    logic [2:0] b_idx0, out_idx0;

    logic       start1, abort1, out_ready1;
    logic       busy1, done1, rd_en1, mac_clr1, mac_en1, bias_en1, relu_en1, out_valid1;
    logic [0:0] w_addr1, x_idx1, b_idx1, out_idx1;

    int checks = 0;
    int errors = 0;

    layer_sequencer #(.M(5), .N(4)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .busy(busy0), .done(done0), .rd_en(rd_en0), .w_addr(w_addr0), .x_idx(x_idx0),
        .mac_clr(mac_clr0), .mac_en(mac_en0), .bias_en(bias_en0), .b_idx(b_idx0),
        .relu_en(relu_en0), .out_valid(out_valid0), .out_ready(out_ready0), .out_idx(out_idx0)
    );

    layer_sequencer #(.M(1), .N(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .rd_en(rd_en1), .w_addr(w_addr1), .x_idx(x_idx1),
        .mac_clr(mac_clr1), .mac_en(mac_en1), .bias_en(bias_en1), .b_idx(b_idx1),
        .relu_en(relu_en1), .out_valid(out_valid1), .out_ready(out_ready1), .out_idx(out_idx1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe bits: {busy, done, rd_en, mac_clr, mac_en, bias_en, relu_en, out_valid}
    // for cycle c after the edge that sampled start, with out_ready held high.
    function automatic logic [7:0] exp_strobes(input int c, input int m, input int n);
        int l;
        int p;
        logic [7:0] s;
        l = n + 5;
        s = '0;
        if (c >= 1 && c <= m * l) begin
            p    = (c - 1) % l;
            s[7] = 1'b1;
            s[4] = (p == 0);
            s[5] = (p >= 1) && (p <= n);
            s[3] = (p >= 2) && (p <= n + 1);
            s[2] = (p == n + 2);
            s[1] = (p == n + 3);
            s[0] = (p == n + 4);
        end else if (c == m * l + 1) begin
            s[7] = 1'b1;
            s[6] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [31:0] obs(input bit sel, input int f);
        case (f)
            0: obs = sel ? {24'd0, busy1, done1, rd_en1, mac_clr1, mac_en1, bias_en1, relu_en1, out_valid1}
                         : {24'd0, busy0, done0, rd_en0, mac_clr0, mac_en0, bias_en0, relu_en0, out_valid0};
            1: obs = sel ? 32'(w_addr1) : 32'(w_addr0);
            2: obs = sel ? 32'(x_idx1)  : 32'(x_idx0);
            3: obs = sel ? 32'(b_idx1)  : 32'(b_idx0);
            default: obs = sel ? 32'(out_idx1) : 32'(out_idx0);
        endcase
    endfunction

    // Entered in cycle 0 with start already driven; walks cycles 1..last.
    task automatic check_run(input bit sel, input int m, input int n, input int last,
                             input int st_at, input int st_len, input bit hold);
        int l, ec, r, p;
        logic [7:0] es;
        l = n + 5;
        for (int c = 1; c <= last; c++) begin
            step();
            if (!hold) begin
                if (sel) start1 = 1'b0; else start0 = 1'b0;
            end
            if (sel) out_ready1 = !(st_len > 0 && c >= st_at && c < st_at + st_len);
            else     out_ready0 = !(st_len > 0 && c >= st_at && c < st_at + st_len);
            ec = c;
            if (st_len > 0 && c > st_at) ec = (c <= st_at + st_len) ? st_at : c - st_len;
            if (hold && c > m * l + 1) ec = c - (m * l + 2);
            es = exp_strobes(ec, m, n);
            r  = (ec > 0) ? (ec - 1) / l : 0;
            p  = (ec > 0) ? (ec - 1) % l : 0;
            check($sformatf("strobes dut%0d c%0d", sel, c), obs(sel, 0), 32'(es));
            if (es[5]) begin
                check($sformatf("w_addr dut%0d c%0d", sel, c), obs(sel, 1), 32'(r * n + p - 1));
                check($sformatf("x_idx dut%0d c%0d", sel, c), obs(sel, 2), 32'(p - 1));
            end
            if (es[2]) check($sformatf("b_idx dut%0d c%0d", sel, c), obs(sel, 3), 32'(r));
            if (es[0]) check($sformatf("out_idx dut%0d c%0d", sel, c), obs(sel, 4), 32'(r));
        end
    endtask

    initial begin
        reset = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; out_ready0 = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b1;
        #12;
        check("reset strobes dut0", obs(0, 0), 32'd0);
        check("reset w_addr dut0", obs(0, 1), 32'd0);
        check("reset out_idx dut0", obs(0, 4), 32'd0);
        check("reset strobes dut1", obs(1, 0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Nominal 5x4 layer: done only in cycle 46
        start0 = 1'b1;
        check_run(0, 5, 4, 48, 0, 0, 1'b0);

        // Backpressure at row 2 WRITE (cycle 27) for 3 cycles
        start0 = 1'b1;
        check_run(0, 5, 4, 52, 27, 3, 1'b0);

        // Abort during row 3 ISSUE, col 1 (cycle 30)
        start0 = 1'b1;
        check_run(0, 5, 4, 30, 0, 0, 1'b0);
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        check("abort idle", obs(0, 0), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("post-abort quiet %0d", i), obs(0, 0), 32'd0);
        end
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        check("restart clr", obs(0, 0), 32'h90);
        step();
        check("restart rd", obs(0, 0), 32'hA0);
        check("restart w_addr", obs(0, 1), 32'd0);
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        step();

        // Asynchronous reset in row 1 BIAS (cycle 16), then full rerun
        start0 = 1'b1;
        check_run(0, 5, 4, 16, 0, 0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async reset strobes", obs(0, 0), 32'd0);
        check("async reset b_idx", obs(0, 3), 32'd0);
        check("async reset w_addr", obs(0, 1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        start0 = 1'b1;
        check_run(0, 5, 4, 48, 0, 0, 1'b0);

        // start held high: DONE-cycle start ignored, next run at cycle 48
        start0 = 1'b1;
        check_run(0, 5, 4, 48, 0, 0, 1'b1);
        start0 = 1'b0;
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        check("hold cleanup idle", obs(0, 0), 32'd0);
        step();

        // M=1, N=1 corner
        start1 = 1'b1;
        check_run(1, 1, 1, 9, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
